// File: rtl/rom_fifo_ctrl.sv
// Stream-to-rom FIFO controller: owns the write/read pointers and occupancy for an
// external dual-port rom and presents the queued words as a valid/ready stream.
module rom_fifo_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr_w,
  output logic [ADDR_W-1:0] mem_addr_r,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(2**ADDR_W);
  localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_out_valid;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full = (r_count == LP_DEPTH);
  assign w_push = in_valid & ~w_full;
  // The output stage is the rom's own dataout register, so a read may only be
  // issued when that register is free or being drained this cycle.
  assign w_pop  = (r_count != '0) & (~r_out_valid | out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_ONE;
        2'b01:   r_count <= r_count - LP_ONE;
        default: r_count <= r_count;
      endcase
      r_out_valid <= w_pop | (r_out_valid & ~out_ready);
    end
  end

  assign in_ready   = ~w_full;
  assign out_valid  = r_out_valid;
  assign out_data   = mem_dataout;
  assign count      = r_count;
  assign full       = w_full;
  assign empty      = (r_count == '0) & ~r_out_valid;
  assign mem_write  = w_push;
  assign mem_read   = w_pop;
  assign mem_addr_w = r_wr_ptr;
  assign mem_addr_r = r_rd_ptr;
  assign mem_datain = in_data;

endmodule
